fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Two-wide front-end sequencer that owns the fetch PC and feeds the 2-entry-per-cycle fetch buffer.
- Issues 64-bit aligned I-cache lookups, splits each block into two 32-bit instruction slots, and offers them to the buffer.
- Advances the PC only when the buffer accepts; handles I-cache miss waits, rollback redirects, and HALT.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- HALT_INST, 32'h0000_0555, encoding that stops fetch after it is delivered.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  global stall; when low, all state holds
- fetch_en  in  1  buffer accepts the offered slots this cycle (already gated by rollback_en)
- rollback_en  in  1  squash and redirect
- rollback_PC  in  64  redirect target
- Icache_addr  out  64  block address = {PC[63:3],3'b0}
- Icache_rd_en  out  1  lookup request
- Icache_hit  in  1  same-cycle hit for Icache_addr
- Icache_data  in  64  block; [31:0] = word 0, [63:32] = word 1
- if_PC_out  out  [2][64]  per-slot PC
- if_NPC_out  out  [2][64]  per-slot PC+4
- if_IR_out  out  [2][32]  per-slot instruction; NOOP_INST when the slot is invalid
- if_target_out  out  [2][64]  per-slot next PC; equals NPC (no prediction)
- if_valid_inst_out  out  [2]  slot valid
- halted  out  1  fetch stopped on HALT

Behaviour:
- State machine: FETCH, MISS, HALTED. Reset gives state=FETCH, PC=RESET_PC, all valids 0, halted=0, and all outputs zero except Icache_addr, which follows PC.
- Icache_rd_en = 1 in FETCH and MISS, 0 in HALTED.
- Outputs depend only on registered state and the I-cache response, never on fetch_en. This avoids a combinational loop, because fetch_en is derived from if_valid_inst_out.
- FETCH with Icache_hit, slot offer:
  - PC[2]==0: slot0 gets PC/word0 and slot1 gets PC+4/word1; valid = 2'b11.
  - PC[2]==1: slot1 gets PC/word1; valid = 2'b10.
- HALT handling:
  - If slot0 holds HALT_INST, slot1 is suppressed and valid = 2'b01.
  - If slot1 holds HALT_INST, it is still delivered.
- FETCH, PC advance (requires en & fetch_en & valid!=0): PC += 4 × popcount(valid), wrapping modulo 2^64. If the delivered group contains HALT, go to HALTED.
- FETCH with !Icache_hit: valid = 0; go to MISS next cycle (if en). PC holds.
- MISS:
  - valid = 0 and the lookup is re-issued every cycle.
  - On Icache_hit, go to FETCH. Slots are offered the cycle after the hit (one bubble).
- HALTED: valid = 0 and halted = 1. Only reset or rollback leaves this state.
- Rollback:
  - rollback_en & en gives PC=rollback_PC and state=FETCH next cycle, from any state.
  - Outputs in the rollback cycle are still driven; the buffer ignores them because fetch_en is 0.
  - Rollback has priority over an accept, a miss, or a HALT in the same cycle.
- Reset has priority over everything, including mid-miss and HALTED.
- en low: state, PC and counters hold; outputs still reflect the current state.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add outputs:
  - perf_fetched [31:0]: instructions accepted.
  - perf_miss_cycles [31:0]: cycles spent in MISS.
  - perf_stall_cycles [31:0]: FETCH cycles with valid!=0 & !fetch_en.
- The counters clear on reset only, saturate at all-ones, and count only when en is high.
- Without the macro, the ports and logic are absent and behaviour is identical.

Decomposition:
- Shared package holds:
  - FETCH_STATE_t enum {FETCH, MISS, HALTED}.
  - IF_OUT_t struct (PC, NPC, inst, target, valid per slot).
  - NUM_SUPER, NOOP_INST, HALT_INST constants.
- One sub-module, fetch_slot_align: purely combinational. Takes PC, Icache_data and hit; produces the slot fields, the valid mask and the halt flag.
- The FSM and PC register stay in fetch_ctrl.

Test Plan:
- Reset, RESET_PC=0, hit, data={32'h47FF041F,32'h40220401}, fetch_en=1 -> valid=2'b11, PCs 0/4, targets 4/8; next cycle PC=8.
- PC=0x0C aligned odd, hit -> valid=2'b10, if_PC_out[1]=0x0C, IR=upper word; after accept, PC=0x10.
- Hit with fetch_en=0 for 3 cycles -> same slots held stable and PC unchanged; accepted on the 4th cycle.
- Miss at PC=0x20 for 5 cycles, then hit -> valid=0 through the miss plus one bubble, then 2'b11 at 0x20/0x24 (with FETCH_PERF_EN: perf_miss_cycles=5).
- Word0=HALT_INST at PC=0x40 -> valid=2'b01; after accept, halted=1 and rd_en=0. Rollback to 0x100 -> FETCH, Icache_addr=0x100 next cycle.
- Rollback asserted during MISS with simultaneous hit -> PC=rollback_PC and state=FETCH; old slots never accepted.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_pkg: shared types and constants for the two-wide fetch stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_ctrl_pkg;

  localparam int          NUM_SUPER = 2;
  localparam logic [31:0] NOOP_INST = 32'h47FF_041F;
  localparam logic [31:0] HALT_INST = 32'h0000_0555;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MISS   = 2'd1,
    HALTED = 2'd2
  } FETCH_STATE_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
    logic [63:0] target;
    logic        valid;
  } IF_OUT_t;

  // Saturating 32-bit increment used by the performance counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_slot_align.sv
// ----------------------------------------------------------------------------
// fetch_slot_align: splits a 64-bit I-cache block into two instruction slots.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_slot_align
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_ENC = HALT_INST
) (
  input  logic [63:0]          pc,
  input  logic [63:0]          data,
  input  logic                 hit,
  output IF_OUT_t              slot [NUM_SUPER],
  output logic [NUM_SUPER-1:0] valid,
  output logic                 halt
);

  logic [31:0] word0;
  logic [31:0] word1;

  assign word0 = data[31:0];
  assign word1 = data[63:32];

  // A HALT in slot 0 suppresses slot 1; a HALT in slot 1 is still delivered.
  always_comb begin
    valid = '0;
    halt  = 1'b0;
    if (hit) begin
      if (!pc[2]) begin
        if (word0 == HALT_ENC) begin
          valid = 2'b01;
          halt  = 1'b1;
        end else begin
          valid = 2'b11;
          halt  = (word1 == HALT_ENC);
        end
      end else begin
        valid = 2'b10;
        halt  = (word1 == HALT_ENC);
      end
    end
  end

  for (genvar i = 0; i < NUM_SUPER; i++) begin : g_slot
    logic [63:0] slot_pc;
    IF_OUT_t     s;

    assign slot_pc = {pc[63:3], 1'(i), pc[1:0]};

    always_comb begin
      s      = '0;
      s.inst = NOOP_INST;
      if (valid[i]) begin
        s.pc     = slot_pc;
        s.npc    = slot_pc + 64'd4;
        s.inst   = data[32*i +: 32];
        s.target = slot_pc + 64'd4;
        s.valid  = 1'b1;
      end
    end

    assign slot[i] = s;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl: two-wide fetch sequencer; optional counters under FETCH_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_INST = 32'h0000_0555
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        fetch_en,
  input  logic        rollback_en,
  input  logic [63:0] rollback_PC,
  output logic [63:0] Icache_addr,
  output logic        Icache_rd_en,
  input  logic        Icache_hit,
  input  logic [63:0] Icache_data,
  output logic [63:0] if_PC_out         [2],
  output logic [63:0] if_NPC_out        [2],
  output logic [31:0] if_IR_out         [2],
  output logic [63:0] if_target_out     [2],
  output logic [1:0]  if_valid_inst_out,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cycles,
  output logic [31:0] perf_stall_cycles,
`endif
  output logic        halted
);

  import fetch_ctrl_pkg::*;

  FETCH_STATE_t state, state_next;
  logic [63:0]  pc, pc_next;
  IF_OUT_t      slot [NUM_SUPER];
  logic [1:0]   valid;
  logic         halt_seen;
  logic         accept;
  logic [1:0]   n_valid;

  fetch_slot_align #(.HALT_ENC(HALT_INST)) u_align (
    .pc    (pc),
    .data  (Icache_data),
    .hit   (Icache_hit && state == FETCH),
    .slot  (slot),
    .valid (valid),
    .halt  (halt_seen)
  );

  assign accept  = fetch_en && (valid != 2'b00);
  assign n_valid = {1'b0, valid[0]} + {1'b0, valid[1]};

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (rollback_en) begin
      state_next = FETCH;
      pc_next    = rollback_PC;
    end else begin
      case (state)
        FETCH: begin
          if (!Icache_hit) begin
            state_next = MISS;
          end else if (accept) begin
            pc_next = pc + {60'd0, n_valid, 2'b00};
            if (halt_seen) state_next = HALTED;
          end
        end
        MISS:    if (Icache_hit) state_next = FETCH;
        HALTED:  state_next = HALTED;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else if (en) begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Everything except the block address reads as zero while reset is held.
  assign Icache_addr       = {pc[63:3], 3'b000};
  assign Icache_rd_en      = !reset && (state != HALTED);
  assign halted            = !reset && (state == HALTED);
  assign if_valid_inst_out = reset ? 2'b00 : valid;

  for (genvar i = 0; i < NUM_SUPER; i++) begin : g_out
    assign if_PC_out[i]     = reset ? 64'd0 : slot[i].pc;
    assign if_NPC_out[i]    = reset ? 64'd0 : slot[i].npc;
    assign if_IR_out[i]     = reset ? 32'd0 : slot[i].inst;
    assign if_target_out[i] = reset ? 64'd0 : slot[i].target;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched      <= '0;
      perf_miss_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (en) begin
      if (accept) perf_fetched <= sat_add32(perf_fetched, n_valid);
      if (state == MISS) perf_miss_cycles <= sat_add32(perf_miss_cycles, 2'd1);
      if (valid != 2'b00 && !fetch_en) perf_stall_cycles <= sat_add32(perf_stall_cycles, 2'd1);
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset, en, fetch_en, rollback_en, Icache_hit;
  logic [63:0] rollback_PC, Icache_data;
  logic [63:0] Icache_addr;
  logic        Icache_rd_en, halted;
  logic [63:0] if_PC_out [2];
  logic [63:0] if_NPC_out [2];
  logic [31:0] if_IR_out [2];
  logic [63:0] if_target_out [2];
  logic [1:0]  if_valid_inst_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_miss_cycles, perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fetch_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .en                (en),
    .fetch_en          (fetch_en),
    .rollback_en       (rollback_en),
    .rollback_PC       (rollback_PC),
    .Icache_addr       (Icache_addr),
    .Icache_rd_en      (Icache_rd_en),
    .Icache_hit        (Icache_hit),
    .Icache_data       (Icache_data),
    .if_PC_out         (if_PC_out),
    .if_NPC_out        (if_NPC_out),
    .if_IR_out         (if_IR_out),
    .if_target_out     (if_target_out),
    .if_valid_inst_out (if_valid_inst_out),
`ifdef FETCH_PERF_EN
    .perf_fetched      (perf_fetched),
    .perf_miss_cycles  (perf_miss_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .halted            (halted)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; fetch_en = 1'b0; rollback_en = 1'b0;
    rollback_PC = '0; Icache_hit = 1'b0; Icache_data = '0;
    repeat (2) tick();
    #1;
    check_eq("rst_valid", 64'(if_valid_inst_out), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_rd_en", 64'(Icache_rd_en), 64'd0);
    check_eq("rst_addr", Icache_addr, 64'h0);

    // Aligned pair at RESET_PC
    reset = 1'b0; Icache_hit = 1'b1; fetch_en = 1'b1;
    Icache_data = {32'h47FF_041F, 32'h4022_0401};
    #1;
    check_eq("t1_valid", 64'(if_valid_inst_out), 64'd3);
    check_eq("t1_pc0", if_PC_out[0], 64'h0);
    check_eq("t1_pc1", if_PC_out[1], 64'h4);
    check_eq("t1_tgt0", if_target_out[0], 64'h4);
    check_eq("t1_tgt1", if_target_out[1], 64'h8);
    check_eq("t1_ir0", 64'(if_IR_out[0]), 64'h4022_0401);
    check_eq("t1_ir1", 64'(if_IR_out[1]), 64'h47FF_041F);
    check_eq("t1_rd_en", 64'(Icache_rd_en), 64'd1);
    tick();
    check_eq("t1_next_pc0", if_PC_out[0], 64'h8);

    // Odd-aligned PC via rollback
    fetch_en = 1'b0; rollback_en = 1'b1; rollback_PC = 64'hC;
    #1;
    check_eq("t1_addr", Icache_addr, 64'h8);
    tick();
    rollback_en = 1'b0;
    #1;
    check_eq("t2_addr", Icache_addr, 64'h8);
    check_eq("t2_valid", 64'(if_valid_inst_out), 64'd2);
    check_eq("t2_pc1", if_PC_out[1], 64'hC);
    check_eq("t2_npc1", if_NPC_out[1], 64'h10);
    check_eq("t2_ir1", 64'(if_IR_out[1]), 64'h47FF_041F);
    check_eq("t2_ir0_noop", 64'(if_IR_out[0]), 64'h47FF_041F);
    fetch_en = 1'b1;
    tick();
    check_eq("t2_adv_addr", Icache_addr, 64'h10);

    // Stall three cycles with a hit, then accept
    fetch_en = 1'b0; Icache_data = {32'hAAAA_0001, 32'hBBBB_0002};
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t3_hold_valid", 64'(if_valid_inst_out), 64'd3);
      check_eq("t3_hold_ir0", 64'(if_IR_out[0]), 64'hBBBB_0002);
      tick();
      check_eq("t3_hold_addr", Icache_addr, 64'h10);
    end
    fetch_en = 1'b1;
    tick();
    check_eq("t3_accept_addr", Icache_addr, 64'h18);

    // Miss at 0x20: five miss cycles, hit on the last, one bubble
    fetch_en = 1'b0; rollback_en = 1'b1; rollback_PC = 64'h20;
    tick();
    rollback_en = 1'b0; Icache_hit = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("t4_miss_valid", 64'(if_valid_inst_out), 64'd0);
      check_eq("t4_miss_rd_en", 64'(Icache_rd_en), 64'd1);
      tick();
    end
    Icache_hit = 1'b1; Icache_data = {32'h47FF_041F, 32'h4022_0401};
    #1;
    check_eq("t4_hit_bubble", 64'(if_valid_inst_out), 64'd0);
    check_eq("t4_addr", Icache_addr, 64'h20);
    tick();
    check_eq("t4_valid", 64'(if_valid_inst_out), 64'd3);
    check_eq("t4_pc0", if_PC_out[0], 64'h20);
    check_eq("t4_pc1", if_PC_out[1], 64'h24);
`ifdef FETCH_PERF_EN
    check_eq("t4_perf_miss", 64'(perf_miss_cycles), 64'd5);
`endif
    tick();
    check_eq("t4_adv_addr", Icache_addr, 64'h28);

    // HALT in word 0 at 0x40
    fetch_en = 1'b0; rollback_en = 1'b1; rollback_PC = 64'h40;
    Icache_data = {32'h1234_5678, 32'h0000_0555};
    tick();
    rollback_en = 1'b0;
    #1;
    check_eq("t5_valid", 64'(if_valid_inst_out), 64'd1);
    check_eq("t5_ir0", 64'(if_IR_out[0]), 64'h0000_0555);
    check_eq("t5_ir1_noop", 64'(if_IR_out[1]), 64'h47FF_041F);
    fetch_en = 1'b1;
    tick();
    check_eq("t5_halted", 64'(halted), 64'd1);
    check_eq("t5_rd_en", 64'(Icache_rd_en), 64'd0);
    check_eq("t5_valid_off", 64'(if_valid_inst_out), 64'd0);
    tick();
    check_eq("t5_stay_halted", 64'(halted), 64'd1);
    fetch_en = 1'b0; rollback_en = 1'b1; rollback_PC = 64'h100;
    tick();
    rollback_en = 1'b0; Icache_hit = 1'b0;
    #1;
    check_eq("t5_rb_addr", Icache_addr, 64'h100);
    check_eq("t5_rb_halted", 64'(halted), 64'd0);
    check_eq("t5_rb_rd_en", 64'(Icache_rd_en), 64'd1);

    // Rollback during MISS with a simultaneous hit
    tick();
    rollback_en = 1'b1; rollback_PC = 64'h200; Icache_hit = 1'b1;
    Icache_data = {32'h0000_0555, 32'h1111_2222};
    tick();
    rollback_en = 1'b0; fetch_en = 1'b0;
    #1;
    check_eq("t6_addr", Icache_addr, 64'h200);
    check_eq("t6_valid", 64'(if_valid_inst_out), 64'd3);
    check_eq("t6_pc0", if_PC_out[0], 64'h200);

    // en low freezes state even with accept
    en = 1'b0; fetch_en = 1'b1;
    tick();
    check_eq("t7_en_hold", Icache_addr, 64'h200);
    en = 1'b1;

    // HALT in slot 1 is delivered, then fetch stops
    #1;
    check_eq("t8_ir1_halt", 64'(if_IR_out[1]), 64'h0000_0555);
    tick();
    check_eq("t8_halted", 64'(halted), 64'd1);
    check_eq("t8_addr", Icache_addr, 64'h208);

    // Reset out of HALTED
    reset = 1'b1; fetch_en = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_eq("t9_addr", Icache_addr, 64'h0);
    check_eq("t9_halted", 64'(halted), 64'd0);
    check_eq("t9_valid", 64'(if_valid_inst_out), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
